// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: opcode map, FSM encoding, error codes
// and instruction field positions.
package alu_sequencer_pkg;

  localparam logic [7:0] OP_ADD       = 8'h00;
  localparam logic [7:0] OP_CMP       = 8'h0A;
  localparam logic [7:0] OP_CMPI      = 8'h0B;
  localparam logic [7:0] OP_CMPU      = 8'h0C;
  localparam logic [7:0] OP_NOP       = 8'h17;
  localparam logic [7:0] OP_HALT      = 8'hFF;
  localparam logic [7:0] OP_LAST_FLAG = OP_CMPU;
  localparam logic [7:0] OP_LAST_EXEC = OP_NOP;

  localparam logic [15:0] INSTR_NOP = {OP_NOP, 8'h00};

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 8;
  localparam int RD_MSB  = 7;
  localparam int RD_LSB  = 4;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALTED    = 3'd5
  } state_t;

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    return 16'h0001 << idx;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/alu_sequencer_opclass.sv
// Combinational opcode classifier: which side effects an opcode has, and whether
// it ends execution.
module alu_seq_opclass
  import alu_sequencer_pkg::*;
(
  input  logic [7:0] opcode,
  output logic       writes_reg,
  output logic       writes_flags,
  output logic       is_halt,
  output logic       is_illegal
);

  logic is_compare_or_nop;

  assign is_halt           = (opcode == OP_HALT);
  assign is_illegal        = (opcode > OP_LAST_EXEC) && !is_halt;
  assign is_compare_or_nop = (opcode == OP_CMP) || (opcode == OP_CMPI) ||
                             (opcode == OP_CMPU) || (opcode == OP_NOP);
  assign writes_reg        = !is_halt && !is_illegal && !is_compare_or_nop;
  assign writes_flags      = (opcode <= OP_LAST_FLAG);

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute/writeback controller driving the ALU + register-bank datapath.
// All outputs come straight from flops so the datapath sees glitch-free enables.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int MEM_TIMEOUT = 15,
  parameter int START_PC    = 0
) (
  input  logic              Clocks,
  input  logic              reset,
  input  logic              start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_data,
  output logic [15:0]       instr_out,
  output logic [15:0]       reg_we,
  output logic              flag_we,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       retired,
  output logic              busy,
  output logic              halted,
  output logic [1:0]        err
);

  localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);
  localparam logic [ADDR_W-1:0] START_ADDR  = ADDR_W'(START_PC);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [15:0]         instr_q, instr_d;
  logic [15:0]         reg_we_q, reg_we_d;
  logic                flag_we_q, flag_we_d;
  logic                mem_req_q, mem_req_d;
  logic [15:0]         retired_q, retired_d;
  logic [1:0]          err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic writes_reg, writes_flags, is_halt, is_illegal;

  alu_seq_opclass u_opclass (
    .opcode      (instr_q[OPC_MSB:OPC_LSB]),
    .writes_reg  (writes_reg),
    .writes_flags(writes_flags),
    .is_halt     (is_halt),
    .is_illegal  (is_illegal)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    reg_we_d  = '0;
    flag_we_d = 1'b0;
    mem_req_d = 1'b0;
    retired_d = retired_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_d   = ST_FETCH;
          pc_d      = START_ADDR;
          err_d     = ERR_NONE;
          retired_d = '0;
          cnt_d     = '0;
          mem_req_d = 1'b1;
        end
      end
      ST_FETCH: begin
        // An ack arriving on the timeout cycle still completes the fetch.
        if (mem_ack) begin
          instr_d = mem_data;
          cnt_d   = '0;
          state_d = ST_DECODE;
        end else if (cnt_q == TIMEOUT_CNT) begin
          err_d   = ERR_TIMEOUT;
          cnt_d   = '0;
          state_d = ST_HALTED;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          mem_req_d = 1'b1;
        end
      end
      ST_DECODE: begin
        if (is_halt) begin
          retired_d = sat_inc16(retired_q);
          state_d   = ST_HALTED;
        end else if (is_illegal) begin
          err_d   = ERR_ILLEGAL;
          state_d = ST_HALTED;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        reg_we_d  = writes_reg ? onehot16(instr_q[RD_MSB:RD_LSB]) : '0;
        flag_we_d = writes_flags;
        state_d   = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        pc_d      = pc_q + 1'b1;
        retired_d = sat_inc16(retired_q);
        mem_req_d = 1'b1;
        state_d   = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clocks or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= START_ADDR;
      instr_q   <= INSTR_NOP;
      reg_we_q  <= '0;
      flag_we_q <= 1'b0;
      mem_req_q <= 1'b0;
      retired_q <= '0;
      err_q     <= ERR_NONE;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      reg_we_q  <= reg_we_d;
      flag_we_q <= flag_we_d;
      mem_req_q <= mem_req_d;
      retired_q <= retired_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = pc_q;
  assign pc        = pc_q;
  assign instr_out = instr_q;
  assign reg_we    = reg_we_q;
  assign flag_we   = flag_we_q;
  assign retired   = retired_q;
  assign err       = err_q;
  assign halted    = (state_q == ST_HALTED);
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_HALTED);

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a program-level reference model queues expected
// fetches and writeback enables; a monitor pops and compares as the DUT produces them.
module tb_alu_sequencer;

  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          Clocks = 1'b0;
  logic          reset  = 1'b0;
  logic          start  = 1'b0;
  logic          mem_ack = 1'b0;
  logic [15:0]   mem_data = 16'h0;
  logic          mem_req, flag_we, busy, halted;
  logic [AW-1:0] mem_addr, pc;
  logic [15:0]   instr_out, reg_we, retired;
  logic [1:0]    err;

  always #5 Clocks = ~Clocks;

  alu_sequencer #(.ADDR_W(AW), .MEM_TIMEOUT(15), .START_PC(0)) dut (
    .Clocks(Clocks), .reset(reset), .start(start),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .instr_out(instr_out), .reg_we(reg_we), .flag_we(flag_we), .pc(pc),
    .retired(retired), .busy(busy), .halted(halted), .err(err)
  );

  typedef struct { int addr; int ret; } fetch_t;
  typedef struct { logic [15:0] we; logic fl; } en_t;

  fetch_t      fetch_q[$];
  en_t         en_q[$];
  logic [15:0] mem [0:DEPTH-1];
  int          checks = 0;
  int          errors = 0;
  int          wait_max = 0;
  bit          no_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory responder: random wait states, junk data whenever no fetch is pending.
  initial begin
    int waited = 0;
    int target = 0;
    forever begin
      @(negedge Clocks);
      if (mem_req && reset && !no_ack) begin
        if (waited >= target) begin
          mem_ack  = 1'b1;
          mem_data = mem[mem_addr];
        end else begin
          mem_ack  = 1'b0;
          mem_data = 16'($urandom);
          waited++;
        end
      end else begin
        mem_ack  = 1'b0;
        mem_data = 16'($urandom);
        waited   = 0;
        target   = $urandom_range(0, wait_max);
      end
    end
  end

  // Monitor: each new fetch and each enable pulse is matched against the scoreboard.
  initial begin
    bit     prev_req = 1'b0;
    fetch_t f;
    en_t    e;
    forever begin
      @(negedge Clocks);
      if (!reset) begin
        prev_req = 1'b0;
      end else begin
        if (mem_req && !prev_req) begin
          if (fetch_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_fetch: addr 0x%0h retired %0d, none expected", mem_addr, retired);
          end else begin
            f = fetch_q.pop_front();
            check("fetch_addr", 32'(mem_addr), f.addr);
            check("fetch_retired", 32'(retired), f.ret);
          end
        end
        prev_req = mem_req;
        if (reg_we != 16'h0 || flag_we) begin
          if (en_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_enable: reg_we 0x%0h flag_we %0b, none expected", reg_we, flag_we);
          end else begin
            e = en_q.pop_front();
            check("reg_we", 32'(reg_we), 32'(e.we));
            check("flag_we", 32'(flag_we), 32'(e.fl));
          end
        end
      end
    end
  end

  // Program-level model: walks the instruction memory and queues what must be observed.
  task automatic model(input int max_instr, output int epc, output int eret, output int eerr);
    int p, r;
    logic [7:0] op;
    logic [3:0] rd;
    en_t e;
    p = 0; r = 0; eerr = 0;
    for (int n = 0; n <= max_instr; n++) begin
      fetch_q.push_back('{p, r});
      if (n == max_instr) break;
      op = mem[p][15:8];
      rd = mem[p][7:4];
      if (op == 8'hFF) begin
        if (r < 65535) r++;
        break;
      end
      if (op > 8'h17) begin
        eerr = 2;
        break;
      end
      e.we = (op == 8'h0A || op == 8'h0B || op == 8'h0C || op == 8'h17) ? 16'h0 : (16'h1 << rd);
      e.fl = (op <= 8'h0C);
      if (e.we != 16'h0 || e.fl) en_q.push_back(e);
      p = (p + 1) % DEPTH;
      if (r < 65535) r++;
    end
    epc = p; eret = r;
  endtask

  task automatic pulse_start();
    @(negedge Clocks);
    start = 1'b1;
    @(negedge Clocks);
    start = 1'b0;
  endtask

  task automatic run_to_halt(input string tag, input int epc, input int eret, input int eerr);
    int n = 0;
    while (!halted && n < 600) begin
      @(negedge Clocks);
      n++;
    end
    check({tag, "_halted"}, 32'(halted), 1);
    check({tag, "_pc"}, 32'(pc), epc);
    check({tag, "_retired"}, 32'(retired), eret);
    check({tag, "_err"}, 32'(err), eerr);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_mem_req"}, 32'(mem_req), 0);
    check({tag, "_fetch_left"}, fetch_q.size(), 0);
    check({tag, "_enable_left"}, en_q.size(), 0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
  endtask

  initial begin
    int epc, eret, eerr, len, op, n;

    // Reset state
    repeat (3) @(negedge Clocks);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_reg_we", 32'(reg_we), 0);
    check("rst_flag_we", 32'(flag_we), 0);
    check("rst_pc", 32'(pc), 0);
    check("rst_retired", 32'(retired), 0);
    check("rst_err", 32'(err), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_instr", 32'(instr_out), 32'h1700);
    reset = 1'b1;
    repeat (2) @(negedge Clocks);

    // ADD r1,r2 then HALT, zero-wait memory
    wait_max = 0;
    clear_mem();
    mem[0] = 16'h0012; mem[1] = 16'hFF00;
    model(100, epc, eret, eerr);
    pulse_start();
    check("add_busy", 32'(busy), 1);
    run_to_halt("add_halt", epc, eret, eerr);
    check("add_pc_abs", 32'(pc), 1);
    check("add_retired_abs", 32'(retired), 2);

    // CMP then NOP then HALT
    clear_mem();
    mem[0] = 16'h0A34; mem[1] = 16'h1755; mem[2] = 16'hFF00;
    model(100, epc, eret, eerr);
    pulse_start();
    run_to_halt("cmp_nop", epc, eret, eerr);

    // Memory never acknowledges
    no_ack = 1'b1;
    fetch_q.push_back('{0, 0});
    pulse_start();
    run_to_halt("timeout", 0, 0, 1);
    no_ack = 1'b0;
    clear_mem();
    mem[0] = 16'h0145; mem[1] = 16'hFF00;
    model(100, epc, eret, eerr);
    pulse_start();
    check("restart_err", 32'(err), 0);
    check("restart_pc", 32'(pc), 0);
    run_to_halt("restart", epc, eret, eerr);

    // Illegal opcode after one good instruction
    clear_mem();
    mem[0] = 16'h0012; mem[1] = 16'h2000;
    model(100, epc, eret, eerr);
    pulse_start();
    run_to_halt("illegal", epc, eret, eerr);
    check("illegal_err_abs", 32'(err), 2);

    // Random programs with random wait states
    for (int t = 0; t < 20; t++) begin
      wait_max = $urandom_range(0, 3);
      clear_mem();
      len = $urandom_range(1, DEPTH - 2);
      for (int i = 0; i < len; i++) begin
        op = $urandom_range(0, 8'h17);
        mem[i] = {8'(op), 8'($urandom)};
      end
      if ($urandom_range(0, 4) == 0) mem[len] = {8'($urandom_range(8'h18, 8'hFE)), 8'($urandom)};
      else mem[len] = {8'hFF, 8'($urandom)};
      model(100, epc, eret, eerr);
      pulse_start();
      run_to_halt("random", epc, eret, eerr);
    end

    // PC wrap: a full memory of ADDs, no HALT, then async reset mid-cycle
    wait_max = 1;
    for (int i = 0; i < DEPTH; i++) mem[i] = {8'h00, 8'($urandom)};
    model(DEPTH, epc, eret, eerr);
    pulse_start();
    n = 0;
    while (fetch_q.size() != 0 && n < 400) begin
      @(posedge Clocks);
      #2;
      n++;
    end
    check("wrap_fetch_left", fetch_q.size(), 0);
    check("wrap_retired", 32'(retired), DEPTH);
    reset = 1'b0;
    #1;
    check("wrap_rst_pc", 32'(pc), 0);
    check("wrap_rst_busy", 32'(busy), 0);
    fetch_q.delete();
    en_q.delete();
    @(negedge Clocks);
    reset = 1'b1;

    // Async reset while the writeback enables are high
    clear_mem();
    mem[0] = 16'h0123; mem[1] = 16'h0234; mem[2] = 16'hFF00;
    model(100, epc, eret, eerr);
    pulse_start();
    n = 0;
    while (reg_we == 16'h0 && n < 100) begin
      @(posedge Clocks);
      #2;
      n++;
    end
    check("wb_reached", 32'(reg_we != 16'h0), 1);
    reset = 1'b0;
    #1;
    check("wbrst_reg_we", 32'(reg_we), 0);
    check("wbrst_flag_we", 32'(flag_we), 0);
    check("wbrst_busy", 32'(busy), 0);
    check("wbrst_halted", 32'(halted), 0);
    check("wbrst_pc", 32'(pc), 0);
    check("wbrst_retired", 32'(retired), 0);
    fetch_q.delete();
    en_q.delete();
    @(negedge Clocks);
    reset = 1'b1;
    repeat (2) @(negedge Clocks);
    check("wbrst_no_enable", 32'({reg_we, flag_we}), 0);

    // Start pulse while busy must not restart the program
    wait_max = 2;
    clear_mem();
    for (int i = 0; i < 6; i++) mem[i] = {8'($urandom_range(0, 8'h17)), 8'($urandom)};
    mem[6] = 16'hFF00;
    model(100, epc, eret, eerr);
    pulse_start();
    n = 0;
    while (retired < 16'd2 && n < 200) begin
      @(negedge Clocks);
      n++;
    end
    check("busy_before_start", 32'(busy), 1);
    pulse_start();
    run_to_halt("busy_start", epc, eret, eerr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, %0d checks", checks);
    $fatal(1);
  end

endmodule
